// File: rtl/ccff_bitstream_loader.sv
// Serial configuration-chain driver: streams config words into a ccff chain
// through ccff_head/config_enable and returns the previous chain contents as readback words.
module ccff_bitstream_loader #(
    parameter int CHAIN_LENGTH = 64,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic [0:WORD_WIDTH-1] cfg_word,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  config_enable,
    output logic                  ccff_head,
    input  logic                  ccff_tail,
    output logic [0:WORD_WIDTH-1] rd_word,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
    localparam int IDX_W = $clog2(WORD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LENGTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [0:WORD_WIDTH-1] tx_sreg_q, tx_sreg_d;
    logic [0:WORD_WIDTH-1] rx_sreg_q, rx_sreg_d;
    logic [0:WORD_WIDTH-1] rd_word_q, rd_word_d;
    logic                  cfg_ready_q, cfg_ready_d;
    logic                  config_enable_q, config_enable_d;
    logic                  ccff_head_q, ccff_head_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;

    // cfg_ready_q is exactly "state is FETCH", so it doubles as the handshake qualifier
    assign accept = cfg_valid & cfg_ready_q;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q         <= S_IDLE;
            bit_cnt_q       <= '0;
            idx_q           <= '0;
            tx_sreg_q       <= '0;
            rx_sreg_q       <= '0;
            rd_word_q       <= '0;
            cfg_ready_q     <= 1'b0;
            config_enable_q <= 1'b0;
            ccff_head_q     <= 1'b0;
            rd_valid_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            idx_q           <= idx_d;
            tx_sreg_q       <= tx_sreg_d;
            rx_sreg_q       <= rx_sreg_d;
            rd_word_q       <= rd_word_d;
            cfg_ready_q     <= cfg_ready_d;
            config_enable_q <= config_enable_d;
            ccff_head_q     <= ccff_head_d;
            rd_valid_q      <= rd_valid_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: if (accept) state_d = S_SHIFT;
            S_SHIFT: begin
                if (bit_cnt_q == LAST_BIT)   state_d = S_DONE;
                else if (idx_q == LAST_IDX)  state_d = S_FETCH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state and registered outputs, all derived from the upcoming state
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        tx_sreg_d  = tx_sreg_q;
        rx_sreg_d  = rx_sreg_q;
        rd_word_d  = rd_word_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) bit_cnt_d = '0;
            end
            S_FETCH: begin
                if (accept) begin
                    tx_sreg_d = cfg_word;
                    idx_d     = '0;
                end
            end
            S_SHIFT: begin
                rx_sreg_d[idx_q] = ccff_tail;
                bit_cnt_d        = bit_cnt_q + CNT_W'(1);
                if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
                if (state_d != S_SHIFT) begin
                    rd_word_d  = rx_sreg_d;
                    rd_valid_d = 1'b1;
                    rx_sreg_d  = '0;
                end
            end
            default: ;
        endcase

        cfg_ready_d     = (state_d == S_FETCH);
        config_enable_d = (state_d == S_SHIFT);
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_DONE);
        ccff_head_d     = (state_d == S_SHIFT) ? tx_sreg_d[idx_d] : ccff_head_q;
    end

    assign cfg_ready     = cfg_ready_q;
    assign config_enable = config_enable_q;
    assign ccff_head     = ccff_head_q;
    assign rd_word       = rd_word_q;
    assign rd_valid      = rd_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: two instances (12-FF and 16-FF chains, 8-bit words)
// driven through one load task and checked against a bit-list model of the chain contents.
module tb_ccff_bitstream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       pReset, start, cfg_valid, sel;
    logic [7:0] word_val;
    logic [0:7] cw;

    always_comb begin
        for (int i = 0; i < 8; i++) cw[i] = word_val[i];
    end

    logic       start_a, cfg_valid_a, ready_a, en_a, head_a, tail_a, rdv_a, busy_a, done_a;
    logic       start_b, cfg_valid_b, ready_b, en_b, head_b, tail_b, rdv_b, busy_b, done_b;
    logic [0:7] rd_a, rd_b;
    logic [11:0] chain_a;
    logic [15:0] chain_b;

    assign start_a     = start & ~sel;
    assign cfg_valid_a = cfg_valid & ~sel;
    assign start_b     = start & sel;
    assign cfg_valid_b = cfg_valid & sel;

    ccff_bitstream_loader #(.CHAIN_LENGTH(12), .WORD_WIDTH(8)) dut_a (
        .prog_clk(clk), .pReset(pReset), .start(start_a), .cfg_word(cw),
        .cfg_valid(cfg_valid_a), .cfg_ready(ready_a), .config_enable(en_a),
        .ccff_head(head_a), .ccff_tail(tail_a), .rd_word(rd_a), .rd_valid(rdv_a),
        .busy(busy_a), .done(done_a));

    ccff_bitstream_loader #(.CHAIN_LENGTH(16), .WORD_WIDTH(8)) dut_b (
        .prog_clk(clk), .pReset(pReset), .start(start_b), .cfg_word(cw),
        .cfg_valid(cfg_valid_b), .cfg_ready(ready_b), .config_enable(en_b),
        .ccff_head(head_b), .ccff_tail(tail_b), .rd_word(rd_b), .rd_valid(rdv_b),
        .busy(busy_b), .done(done_b));

    // Attached configuration chains; element 0 is the flip-flop fed by ccff_head
    always @(posedge clk) begin
        if (pReset) begin
            chain_a <= '0;
            chain_b <= '0;
        end else begin
            if (en_a) chain_a <= {chain_a[10:0], head_a};
            if (en_b) chain_b <= {chain_b[14:0], head_b};
        end
    end
    assign tail_a = chain_a[11];
    assign tail_b = chain_b[15];

    logic        ready, en, head, rdv, busy, done;
    logic [7:0]  rdn;
    logic [15:0] chain_sel;
    assign ready     = sel ? ready_b : ready_a;
    assign en        = sel ? en_b    : en_a;
    assign head      = sel ? head_b  : head_a;
    assign rdv       = sel ? rdv_b   : rdv_a;
    assign busy      = sel ? busy_b  : busy_a;
    assign done      = sel ? done_b  : done_a;
    assign chain_sel = sel ? chain_b : {4'b0, chain_a};
    always_comb begin
        for (int i = 0; i < 8; i++) rdn[i] = sel ? rd_b[i] : rd_a[i];
    end

    int errors = 0;
    int checks = 0;
    bit prev_bits [2][16];
    bit head_model [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ready"}, ready, 0);
        check_val({tag, "_en"},    en,    0);
        check_val({tag, "_head"},  head,  0);
        check_val({tag, "_rd"},    rdn,   0);
        check_val({tag, "_rdv"},   rdv,   0);
        check_val({tag, "_busy"},  busy,  0);
        check_val({tag, "_done"},  done,  0);
    endtask

    // One complete load on the instance chosen by sel; called #1 after a rising edge
    task automatic run_load(input int w0, input int w1, input int stall_len,
                            input bit mid_start, input bit cyc10_chk);
        int cl, nwords, exp_done, done_cyc, bit_seen, rd_seen, word_i, stall_left, first_en;
        int words [2];
        bit bits [16];
        int exp_rd [2];
        logic [15:0] exp_chain;

        cl = sel ? 16 : 12;
        nwords = (cl + 7) / 8;
        words[0] = w0;
        words[1] = w1;
        for (int k = 0; k < 16; k++) bits[k] = (k < cl) ? words[k / 8][k % 8] : 1'b0;
        for (int j = 0; j < 2; j++) begin
            exp_rd[j] = 0;
            for (int p = 0; p < 8; p++)
                if (j * 8 + p < cl && prev_bits[sel][j * 8 + p]) exp_rd[j] |= (1 << p);
        end
        exp_done = cl + nwords + 1 + stall_len;
        exp_chain = '0;
        for (int k = 0; k < cl; k++) exp_chain[cl - 1 - k] = bits[k];

        // cycle 0: start, with a garbage word offered while still idle
        check_val("idle_ready", ready, 0);
        cfg_valid = 1'b1;
        word_val = 8'($urandom);
        start = 1'b1;
        done_cyc = -1; bit_seen = 0; rd_seen = 0; word_i = 0; first_en = -1;
        stall_left = stall_len;

        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            start = (mid_start && c == 4);
            if (en) begin
                if (first_en < 0) first_en = c;
                if (bit_seen < cl) begin
                    check_val("head_bit", head, bits[bit_seen]);
                    head_model[sel] = bits[bit_seen];
                end
                bit_seen++;
            end else begin
                check_val("head_hold", head, head_model[sel]);
            end
            if (cyc10_chk && c == 10) check_val("en_cyc10", en, 0);
            if (rdv) begin
                if (rd_seen < nwords) check_val("rd_word", rdn, exp_rd[rd_seen]);
                rd_seen++;
            end
            if (done) begin
                done_cyc = c;
                check_val("rdv_with_done", rdv, 1);
                break;
            end
            if (ready && word_i == 1 && stall_left > 0) begin
                check_val("stall_en", en, 0);
                cfg_valid = 1'b0;
                stall_left--;
            end else begin
                cfg_valid = 1'b1;
                word_val = (word_i < 2) ? 8'(words[word_i]) : 8'h00;
                if (ready) word_i++;
            end
        end
        cfg_valid = 1'b0;
        start = 1'b0;

        check_val("done_cycle", done_cyc, exp_done);
        check_val("first_en", first_en, 2);
        check_val("en_count", bit_seen, cl);
        check_val("rd_count", rd_seen, nwords);
        check_val("words_taken", word_i, nwords);
        @(posedge clk); #1;
        check_val("chain", chain_sel, exp_chain);
        check_val("post_busy", busy, 0);
        check_val("post_done", done, 0);
        check_val("post_ready", ready, 0);
        for (int k = 0; k < 16; k++) prev_bits[sel][k] = bits[k];
    endtask

    initial begin
        pReset = 1'b1; start = 1'b0; cfg_valid = 1'b0; sel = 1'b0; word_val = '0;
        for (int s = 0; s < 2; s++) begin
            head_model[s] = 1'b0;
            for (int k = 0; k < 16; k++) prev_bits[s][k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        pReset = 1'b0;
        check_all_zero("rst_a");
        sel = 1'b1; #0;
        check_all_zero("rst_b");
        sel = 1'b0;
        @(posedge clk); #1;

        // basic load, then readback of it, then a stalled second fetch, then ignored start
        run_load(8'hA5, 8'h0F, 0, 1'b0, 1'b1);
        run_load(8'h3C, 8'h05, 0, 1'b0, 1'b0);
        run_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 5, 1'b0, 1'b0);
        run_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 1'b1, 1'b0);

        // reset in the middle of the first word
        cfg_valid = 1'b1; word_val = 8'hFF; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        pReset = 1'b1;
        @(posedge clk); #1;
        pReset = 1'b0;
        cfg_valid = 1'b0;
        check_all_zero("midrst");
        check_val("midrst_chain", chain_sel, 0);
        head_model[0] = 1'b0;
        for (int k = 0; k < 16; k++) prev_bits[0][k] = 1'b0;
        run_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 1'b0, 1'b0);

        // exact multiple chain length
        sel = 1'b1;
        @(posedge clk); #1;
        run_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 1'b0, 1'b1);
        run_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0, 1'b0, 1'b0);

        for (int it = 0; it < 12; it++) begin
            sel = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            run_load(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
